// File: rtl/hack_alu_issue_ctrl_if.sv
// Paired-control Hack ALU issue bundle: instruction port, ALU control/operand
// port and result port of hack_alu_issue_ctrl. slave = issue block, master = environment.
interface hack_alu_issue_ctrl_if;
    localparam int DATA_W = 16;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] d_reg;
    logic [DATA_W-1:0] m_data;

    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic [1:0]        zxnx;
    logic [1:0]        zyny;
    logic [1:0]        fno;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zr;
    logic              alu_ng;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              wr_a;
    logic              wr_d;
    logic              wr_m;
    logic              jump;
    logic              illegal;

    modport slave (
        input  in_valid, instr, a_reg, d_reg, m_data, alu_out, alu_zr, alu_ng, res_ready,
        output in_ready, alu_x, alu_y, zxnx, zyny, fno,
               res_valid, res_data, wr_a, wr_d, wr_m, jump, illegal
    );

    modport master (
        output in_valid, instr, a_reg, d_reg, m_data, alu_out, alu_zr, alu_ng, res_ready,
        input  in_ready, alu_x, alu_y, zxnx, zyny, fno,
               res_valid, res_data, wr_a, wr_d, wr_m, jump, illegal
    );
endinterface

// File: rtl/hack_alu_issue_ctrl.sv
// Hack ALU issue/decode controller: one instruction in flight, ALU_LAT wait states.
// Optional feature macro ILLEGAL_TRAP_EN: trap C-instructions whose bits [14:13] are not 2'b11.
module hack_alu_issue_ctrl #(
    parameter int unsigned ALU_LAT = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    hack_alu_issue_ctrl_if.slave bus
);
    localparam int DATA_W = 16;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       jjj;
    logic [2:0]       ddd;
    logic             accept;
    logic             trap;

    assign accept = bus.in_valid & bus.in_ready;

`ifdef ILLEGAL_TRAP_EN
    assign trap = bus.instr[15] & (bus.instr[14:13] != 2'b11);
`else
    assign trap = 1'b0;
`endif

    function automatic logic jump_of(input logic [2:0] j, input logic zr, input logic ng);
        return (j[2] & ng) | (j[1] & zr) | (j[0] & ~zr & ~ng);
    endfunction

    // Dest/jump fields are only consumed after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            ddd <= bus.instr[5:3];
            jjj <= bus.instr[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.in_ready  <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.wr_a      <= 1'b0;
            bus.wr_d      <= 1'b0;
            bus.wr_m      <= 1'b0;
            bus.jump      <= 1'b0;
            bus.illegal   <= 1'b0;
            bus.alu_x     <= '0;
            bus.alu_y     <= '0;
            bus.zxnx      <= '0;
            bus.zyny      <= '0;
            bus.fno       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.in_ready <= 1'b0;
                        if (bus.instr[15] && !trap) begin
                            bus.zxnx  <= bus.instr[11:10];
                            bus.zyny  <= bus.instr[9:8];
                            bus.fno   <= bus.instr[7:6];
                            bus.alu_x <= bus.d_reg;
                            bus.alu_y <= bus.instr[12] ? bus.m_data : bus.a_reg;
                            cnt       <= CNT_W'(ALU_LAT);
                            state     <= EXEC;
                        end else begin
                            // A-instruction (or trapped C-instruction) bypasses the ALU.
                            bus.res_data  <= trap ? bus.instr : {1'b0, bus.instr[DATA_W-2:0]};
                            bus.wr_a      <= ~trap;
                            bus.wr_d      <= 1'b0;
                            bus.wr_m      <= 1'b0;
                            bus.jump      <= 1'b0;
                            bus.illegal   <= trap;
                            bus.res_valid <= 1'b1;
                            state         <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        bus.res_data  <= bus.alu_out;
                        bus.wr_a      <= ddd[2];
                        bus.wr_d      <= ddd[1];
                        bus.wr_m      <= ddd[0];
                        bus.jump      <= jump_of(jjj, bus.alu_zr, bus.alu_ng);
                        bus.res_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.wr_a      <= 1'b0;
                        bus.wr_d      <= 1'b0;
                        bus.wr_m      <= 1'b0;
                        bus.jump      <= 1'b0;
                        bus.illegal   <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hack_alu_issue_ctrl.sv
// Bench for hack_alu_issue_ctrl: two instances (ALU_LAT=0 and ALU_LAT=2) driven in lockstep,
// each fed by a Hack ALU model whose result pipeline matches its latency.
module tb_hack_alu_issue_ctrl;
    localparam int LAT_A = 0;
    localparam int LAT_B = 2;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [15:0] ins = '0, areg = '0, dreg = '0, mdat = '0;

    hack_alu_issue_ctrl_if if_a ();
    hack_alu_issue_ctrl_if if_b ();

    assign if_a.in_valid = in_valid;  assign if_b.in_valid = in_valid;
    assign if_a.res_ready = res_ready; assign if_b.res_ready = res_ready;
    assign if_a.instr = ins;  assign if_b.instr = ins;
    assign if_a.a_reg = areg; assign if_b.a_reg = areg;
    assign if_a.d_reg = dreg; assign if_b.d_reg = dreg;
    assign if_a.m_data = mdat; assign if_b.m_data = mdat;

    hack_alu_issue_ctrl #(.ALU_LAT(LAT_A)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    hack_alu_issue_ctrl #(.ALU_LAT(LAT_B)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    function automatic logic jump_rule(input logic [2:0] j, input logic [15:0] r);
        return (j[2] && $signed(r) < 0) || (j[1] && r == 16'h0000) || (j[0] && $signed(r) > 0);
    endfunction

    // ALU for instance A: combinational. ALU for instance B: two register stages.
    logic [15:0] alu_a_c, alu_b_c, alu_b_p1, alu_b_p2;
    assign alu_a_c = hack_alu(if_a.alu_x, if_a.alu_y, {if_a.zxnx, if_a.zyny, if_a.fno});
    assign alu_b_c = hack_alu(if_b.alu_x, if_b.alu_y, {if_b.zxnx, if_b.zyny, if_b.fno});
    always @(posedge clk) begin
        alu_b_p1 <= alu_b_c;
        alu_b_p2 <= alu_b_p1;
    end
    assign if_a.alu_out = alu_a_c;
    assign if_a.alu_zr  = (alu_a_c == 16'h0000);
    assign if_a.alu_ng  = alu_a_c[15];
    assign if_b.alu_out = alu_b_p2;
    assign if_b.alu_zr  = (alu_b_p2 == 16'h0000);
    assign if_b.alu_ng  = alu_b_p2[15];

    logic        o_rdy [2], o_vld [2], o_jmp [2], o_ill [2];
    logic [15:0] o_res [2], o_x [2], o_y [2];
    logic [2:0]  o_wr  [2];
    logic [5:0]  o_ctl [2];
    assign o_rdy[0] = if_a.in_ready;  assign o_rdy[1] = if_b.in_ready;
    assign o_vld[0] = if_a.res_valid; assign o_vld[1] = if_b.res_valid;
    assign o_jmp[0] = if_a.jump;      assign o_jmp[1] = if_b.jump;
    assign o_ill[0] = if_a.illegal;   assign o_ill[1] = if_b.illegal;
    assign o_res[0] = if_a.res_data;  assign o_res[1] = if_b.res_data;
    assign o_x[0] = if_a.alu_x;       assign o_x[1] = if_b.alu_x;
    assign o_y[0] = if_a.alu_y;       assign o_y[1] = if_b.alu_y;
    assign o_wr[0] = {if_a.wr_a, if_a.wr_d, if_a.wr_m};
    assign o_wr[1] = {if_b.wr_a, if_b.wr_d, if_b.wr_m};
    assign o_ctl[0] = {if_a.zxnx, if_a.zyny, if_a.fno};
    assign o_ctl[1] = {if_b.zxnx, if_b.zyny, if_b.fno};

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: busy flag, edges left until the result shows, expected result.
    bit          m_idle [2];
    int          m_left [2];
    logic [15:0] m_res [2], m_x [2], m_y [2];
    logic [2:0]  m_wr [2];
    logic        m_jmp [2], m_ill [2];
    logic [5:0]  m_ctl [2];
    logic [15:0] m_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_idle[k] = 1'b1; m_left[k] = 0; m_res[k] = '0; m_wr[k] = '0;
                m_jmp[k] = 1'b0; m_ill[k] = 1'b0; m_ctl[k] = '0; m_x[k] = '0; m_y[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_idle[k]) begin
                    if (in_valid) begin
                        m_idle[k] = 1'b0;
                        m_left[k] = 0;
                        m_jmp[k] = 1'b0;
                        m_ill[k] = 1'b0;
                        if (!ins[15]) begin
                            m_res[k] = {1'b0, ins[14:0]};
                            m_wr[k] = 3'b100;
                        end else if (TRAP && ins[14:13] != 2'b11) begin
                            m_res[k] = ins;
                            m_wr[k] = 3'b000;
                            m_ill[k] = 1'b1;
                        end else begin
                            m_ctl[k] = ins[11:6];
                            m_x[k] = dreg;
                            m_y[k] = ins[12] ? mdat : areg;
                            m_r = hack_alu(m_x[k], m_y[k], m_ctl[k]);
                            m_res[k] = m_r;
                            m_wr[k] = ins[5:3];
                            m_jmp[k] = jump_rule(ins[2:0], m_r);
                            m_left[k] = ((k == 0) ? LAT_A : LAT_B) + 1;
                        end
                    end
                end else if (m_left[k] > 0) begin
                    m_left[k] = m_left[k] - 1;
                end else if (res_ready) begin
                    m_idle[k] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d.in_ready", k), o_rdy[k], m_idle[k]);
            chk($sformatf("d%0d.res_valid", k), o_vld[k], !m_idle[k] && m_left[k] == 0);
            chk($sformatf("d%0d.ctl", k), o_ctl[k], m_ctl[k]);
            chk($sformatf("d%0d.alu_x", k), o_x[k], m_x[k]);
            chk($sformatf("d%0d.alu_y", k), o_y[k], m_y[k]);
            if (!m_idle[k] && m_left[k] == 0) begin
                chk($sformatf("d%0d.res_data", k), o_res[k], m_res[k]);
                chk($sformatf("d%0d.wr", k), o_wr[k], m_wr[k]);
                chk($sformatf("d%0d.jump", k), o_jmp[k], m_jmp[k]);
                chk($sformatf("d%0d.illegal", k), o_ill[k], m_ill[k]);
            end else begin
                chk($sformatf("d%0d.wr_idle", k), o_wr[k], 3'b000);
                chk($sformatf("d%0d.jump_idle", k), o_jmp[k], 1'b0);
                chk($sformatf("d%0d.illegal_idle", k), o_ill[k], 1'b0);
            end
        end
    end

    task automatic wait_idle(input string nm);
        int t = 0;
        while (!(o_rdy[0] && o_rdy[1]) && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (t >= 30) chk({nm, ".idle_timeout"}, 0, 1);
    endtask

    task automatic run(input string nm, input logic [15:0] i, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] m, input logic [15:0] x_res,
                       input logic [2:0] x_wr, input logic x_jmp, input logic x_ill,
                       input int x_lat_a, input int x_lat_b, input int hold);
        bit seen [2];
        int n;
        wait_idle(nm);
        ins = i; areg = a; dreg = d; mdat = m;
        in_valid = 1'b1;
        res_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        seen[0] = 1'b0; seen[1] = 1'b0;
        n = 1;
        while (!(seen[0] && seen[1]) && n <= 20) begin
            for (int k = 0; k < 2; k++) begin
                if (!seen[k] && o_vld[k]) begin
                    seen[k] = 1'b1;
                    chk($sformatf("%s.d%0d.latency", nm, k), n, (k == 0) ? x_lat_a : x_lat_b);
                    chk($sformatf("%s.d%0d.res_data", nm, k), o_res[k], x_res);
                    chk($sformatf("%s.d%0d.wr", nm, k), o_wr[k], x_wr);
                    chk($sformatf("%s.d%0d.jump", nm, k), o_jmp[k], x_jmp);
                    chk($sformatf("%s.d%0d.illegal", nm, k), o_ill[k], x_ill);
                end
            end
            if (!(seen[0] && seen[1])) begin
                @(negedge clk);
                n++;
            end
        end
        if (!(seen[0] && seen[1])) chk({nm, ".result_timeout"}, 0, 1);
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("%s.d%0d.hold_valid", nm, k), o_vld[k], 1'b1);
                    chk($sformatf("%s.d%0d.hold_ready", nm, k), o_rdy[k], 1'b0);
                    chk($sformatf("%s.d%0d.hold_data", nm, k), o_res[k], x_res);
                    chk($sformatf("%s.d%0d.hold_jump", nm, k), o_jmp[k], x_jmp);
                end
            end
            res_ready = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("%s.d%0d.post_ready", nm, k), o_rdy[k], 1'b1);
                chk($sformatf("%s.d%0d.post_valid", nm, k), o_vld[k], 1'b0);
            end
        end
    endtask

    task automatic chk_ctl(input string nm, input logic [5:0] ctl);
        for (int k = 0; k < 2; k++) chk($sformatf("%s.d%0d.ctl", nm, k), o_ctl[k], ctl);
    endtask

    task automatic chk_reset_vals(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.d%0d.in_ready", nm, k), o_rdy[k], 1'b1);
            chk($sformatf("%s.d%0d.res_valid", nm, k), o_vld[k], 1'b0);
            chk($sformatf("%s.d%0d.res_data", nm, k), o_res[k], 16'h0000);
            chk($sformatf("%s.d%0d.wr_jmp_ill", nm, k), {o_wr[k], o_jmp[k], o_ill[k]}, 5'b0);
            chk($sformatf("%s.d%0d.alu_xy", nm, k), {o_x[k], o_y[k]}, 32'h0);
            chk($sformatf("%s.d%0d.ctl", nm, k), o_ctl[k], 6'b0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // D+A;JLT : 100 + (-200) = -100
        run("t1_add_jlt", 16'hE084, 16'hFF38, 16'd100, 16'h0000, 16'hFF9C, 3'b000, 1'b1, 1'b0, 2, 4, 0);
        chk_ctl("t1", 6'b00_00_10);
        // D=D-1
        run("t2_dec", 16'hE390, 16'h0000, 16'd100, 16'h0000, 16'd99, 3'b010, 1'b0, 1'b0, 2, 4, 0);
        chk_ctl("t2", 6'b00_11_10);
        // @5 leaves the ALU controls alone
        run("t3_ainstr", 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'd5, 3'b100, 1'b0, 1'b0, 1, 1, 0);
        chk_ctl("t3", 6'b00_11_10);
        // consumer stalls for three cycles
        run("t4_stall", 16'hE390, 16'h0000, 16'd100, 16'h0000, 16'd99, 3'b010, 1'b0, 1'b0, 2, 4, 3);

        // asynchronous reset while both instances sit in EXEC
        wait_idle("t4_rst");
        ins = 16'hEA87; dreg = 16'h1234; areg = 16'h0005;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("t4_rst");
        rst_n = 1'b1;
        @(negedge clk);

        // 0;JMP
        run("t5_jmp", 16'hEA87, 16'h0005, 16'h1234, 16'h0000, 16'h0000, 3'b000, 1'b1, 1'b0, 2, 4, 0);
        chk_ctl("t5", 6'b10_10_10);
`ifdef ILLEGAL_TRAP_EN
        run("t6_trap", 16'h8010, 16'h0F0F, 16'h00FF, 16'h0000, 16'h8010, 3'b000, 1'b0, 1'b1, 1, 1, 0);
        chk_ctl("t6", 6'b10_10_10);
`else
        run("t6_dand", 16'h8010, 16'h0F0F, 16'h00FF, 16'h0000, 16'h000F, 3'b010, 1'b0, 1'b0, 2, 4, 0);
        chk_ctl("t6", 6'b00_00_00);
`endif
        // DM=D|M selects the memory operand
        run("t7_dorm", 16'hF558, 16'h0000, 16'h0F0F, 16'h3030, 16'h3F3F, 3'b011, 1'b0, 1'b0, 2, 4, 0);
        // D-M;JEQ with equal operands
        run("t8_jeq", 16'hF4C2, 16'h0000, 16'h1234, 16'h1234, 16'h0000, 3'b000, 1'b1, 1'b0, 2, 4, 0);
        // largest A constant
        run("t9_amax", 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 3'b100, 1'b0, 1'b0, 1, 1, 0);
        // D;JGT with the most negative D
        run("t10_jgt", 16'hE301, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 3'b000, 1'b0, 1'b0, 2, 4, 2);

        wait_idle("end");
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
